// File: rtl/ic_bv_skolem_serial.sv
// rtl/ic_bv_skolem_serial.sv - serial IC evaluator and witness generator for (x AND/OR s) UGE/ULE t
// MSB-first digit compare of s against t, then one resolve cycle that registers ic/x/mode.
module ic_bv_skolem_serial #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  input  logic [1:0]   in_mode,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ic,
  output logic [W-1:0] out_x,
  output logic [1:0]   out_mode
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // RESOLVE is the cycle after the last digit, giving the fixed W/D+1 latency.
  typedef enum logic [1:0] {IDLE, RUN, RESOLVE, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   s_sh, t_sh;
  logic [1:0]     mode_q;
  logic           gt, lt;
  logic           last;
  logic           res_ic;
  logic [W-1:0]   res_x;
  logic [D-1:0]   a_k, t_k;

  assign last = (cnt == CW'(N - 1));
  assign a_k  = s_sh[W-1 -: D];
  assign t_k  = t_sh[W-1 -: D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!flush && in_valid) state_nx = RUN;
      RUN:     if (flush) state_nx = IDLE;
               else if (last) state_nx = RESOLVE;
      RESOLVE: state_nx = flush ? IDLE : DONE;
      DONE:    if (flush || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // mode bit0 selects OR, bit1 selects ULE
  always_comb begin
    res_ic = 1'b0;
    res_x  = '0;
    case (mode_q)
      2'b00: begin res_ic = gt | (!gt && !lt); res_x = '1; end
      2'b01: begin res_ic = 1'b1;              res_x = '1; end
      2'b10: begin res_ic = 1'b1;              res_x = '0; end
      2'b11: begin res_ic = lt | (!gt && !lt); res_x = '0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s_sh     <= '0;
      t_sh     <= '0;
      mode_q   <= '0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      out_ic   <= 1'b0;
      out_x    <= '0;
      out_mode <= '0;
    end else begin
      if (state == IDLE && state_nx == RUN) begin
        s_sh   <= in_s;
        t_sh   <= in_t;
        mode_q <= in_mode;
        gt     <= 1'b0;
        lt     <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        s_sh <= s_sh << D;
        t_sh <= t_sh << D;
        cnt  <= cnt + 1'b1;
        // first differing digit decides the order
        if (!gt && !lt) begin
          gt <= (a_k > t_k);
          lt <= (a_k < t_k);
        end
      end else if (state == RESOLVE && !flush) begin
        out_ic   <= res_ic;
        out_x    <= res_ic ? res_x : '0;
        out_mode <= mode_q;
      end
    end
  end

endmodule

// File: tb/tb_ic_bv_skolem_serial.sv
// tb/tb_ic_bv_skolem_serial.sv - directed and random bench for ic_bv_skolem_serial
// Three instances: W=8/D=1, W=32/D=4 and W=4/D=4 (single digit).
module tb_ic_bv_skolem_serial;

  localparam logic [1:0] AND_UGE = 2'b00;
  localparam logic [1:0] OR_UGE  = 2'b01;
  localparam logic [1:0] AND_ULE = 2'b10;
  localparam logic [1:0] OR_ULE  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic [31:0] bus_s, bus_t;
  logic [1:0]  bus_mode;
  logic        flush, out_ready;
  wire  [2:0]  ir, ov, icv;
  wire  [7:0]  x8;
  wire  [31:0] x32;
  wire  [3:0]  x4;
  wire  [1:0]  m8, m32, m4;

  int          sel;
  logic        cur_v, cur_r, cur_ic;
  logic [31:0] cur_x;
  logic [1:0]  cur_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ic_bv_skolem_serial #(.W(8), .D(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_s(bus_s[7:0]), .in_t(bus_t[7:0]), .in_mode(bus_mode), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ic(icv[0]), .out_x(x8), .out_mode(m8));

  ic_bv_skolem_serial #(.W(32), .D(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_s(bus_s), .in_t(bus_t), .in_mode(bus_mode), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ic(icv[1]), .out_x(x32), .out_mode(m32));

  ic_bv_skolem_serial #(.W(4), .D(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_s(bus_s[3:0]), .in_t(bus_t[3:0]), .in_mode(bus_mode), .flush(flush),
    .out_valid(ov[2]), .out_ready(out_ready), .out_ic(icv[2]), .out_x(x4), .out_mode(m4));

  always_comb begin
    cur_v = 1'b0; cur_r = 1'b0; cur_ic = 1'b0; cur_x = '0; cur_m = '0;
    case (sel)
      0: begin cur_v = ov[0]; cur_r = ir[0]; cur_ic = icv[0]; cur_x = {24'b0, x8}; cur_m = m8; end
      1: begin cur_v = ov[1]; cur_r = ir[1]; cur_ic = icv[1]; cur_x = x32;          cur_m = m32; end
      default: begin cur_v = ov[2]; cur_r = ir[2]; cur_ic = icv[2]; cur_x = {28'b0, x4}; cur_m = m4; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input int which, input logic [31:0] s, input logic [31:0] t,
                           input logic [1:0] mode);
    sel = which; bus_s = s; bus_t = t; bus_mode = mode; iv[which] = 1'b1;
    #1 check("accept_ready", cur_r, 1);
    @(posedge clk); #1;
    iv[which] = 1'b0;
    bus_s = $urandom; bus_t = $urandom; bus_mode = ~mode;
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cur_v && lat < 40);
    check("latency", lat, exp_lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_ready", cur_r, 1);
    check("release_valid", cur_v, 0);
  endtask

  task automatic run_job(input int which, input logic [31:0] s, input logic [31:0] t,
                         input logic [1:0] mode, input logic eic, input logic [31:0] ex,
                         input int lat);
    start_job(which, s, t, mode);
    wait_done(lat);
    check("ic", cur_ic, eic);
    check("x", cur_x, ex);
    check("mode", cur_m, mode);
    release_out();
  endtask

  task automatic no_valid_for(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (cur_v) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [7:0] rs, rt, op;
    logic [1:0] rm;
    logic       eic, holds;
    rst_n = 1'b0; iv = '0; bus_s = '0; bus_t = '0; bus_mode = '0;
    flush = 1'b0; out_ready = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cur_r, 1);
    check("rst_valid", cur_v, 0);
    check("rst_ic", cur_ic, 0);
    check("rst_x", cur_x, 0);
    check("rst_mode", cur_m, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(0, 32'hF0, 32'hA5, AND_UGE, 1, 32'hFF, 9);
    run_job(0, 32'h0F, 32'h10, AND_UGE, 0, 32'h00, 9);
    run_job(0, 32'h12, 32'h12, OR_ULE,  1, 32'h00, 9);
    run_job(0, 32'h37, 32'h00, AND_UGE, 1, 32'hFF, 9);
    run_job(0, 32'hFF, 32'hFE, OR_ULE,  0, 32'h00, 9);
    run_job(0, 32'h5A, 32'h5A, AND_UGE, 1, 32'hFF, 9);

    // backpressure: results and in_ready must hold while out_ready is low
    start_job(0, 32'hF0, 32'hA5, AND_UGE);
    wait_done(9);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", cur_v, 1);
      check("bp_ic", cur_ic, 1);
      check("bp_x", cur_x, 32'hFF);
      check("bp_ready", cur_r, 0);
    end
    release_out();

    run_job(0, 32'h00, 32'hFF, OR_UGE, 1, 32'hFF, 9);

    // flush during RUN at digit 3
    start_job(0, 32'h55, 32'h33, AND_ULE);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", cur_r, 1);
    check("flush_keep_ic", cur_ic, 1);
    check("flush_keep_x", cur_x, 32'hFF);
    check("flush_keep_mode", cur_m, OR_UGE);
    no_valid_for("flush_no_valid", 12);
    run_job(0, 32'h00, 32'hFF, AND_ULE, 1, 32'h00, 9);

    // flush in IDLE beats a simultaneous offer
    bus_s = 32'h01; bus_t = 32'h02; bus_mode = AND_UGE;
    iv[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0; flush = 1'b0;
    check("idle_flush_ready", cur_r, 1);
    no_valid_for("idle_flush_no_valid", 12);

    // async reset mid-RUN, after a job left nonzero outputs
    run_job(0, 32'h00, 32'hFF, OR_UGE, 1, 32'hFF, 9);
    start_job(0, 32'h10, 32'h20, OR_UGE);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rrun_valid", cur_v, 0);
    check("rrun_ic", cur_ic, 0);
    check("rrun_x", cur_x, 0);
    check("rrun_mode", cur_m, 0);
    check("rrun_ready", cur_r, 1);
    @(negedge clk) rst_n = 1'b1;
    no_valid_for("rrun_no_valid", 12);

    // async reset in DONE
    start_job(0, 32'h10, 32'h20, OR_UGE);
    wait_done(9);
    rst_n = 1'b0;
    #1;
    check("rdone_valid", cur_v, 0);
    check("rdone_ic", cur_ic, 0);
    check("rdone_x", cur_x, 0);
    check("rdone_ready", cur_r, 1);
    @(negedge clk) rst_n = 1'b1;
    no_valid_for("rdone_no_valid", 12);

    run_job(1, 32'hFFFFFFFF, 32'hFFFFFFFE, OR_ULE,  0, 32'h0, 9);
    run_job(1, 32'hFFFFFFFF, 32'hFFFFFFFF, OR_ULE,  1, 32'h0, 9);
    run_job(1, 32'h80000000, 32'h7FFFFFFF, AND_UGE, 1, 32'hFFFFFFFF, 9);
    run_job(1, 32'h12345678, 32'h12345679, AND_UGE, 0, 32'h0, 9);

    run_job(2, 32'h3, 32'h5, AND_UGE, 0, 32'h0, 2);
    run_job(2, 32'h3, 32'h5, OR_ULE,  1, 32'h0, 2);
    run_job(2, 32'h9, 32'h2, AND_ULE, 1, 32'h0, 2);

    // random regression: ic vs direct compare, and witness must satisfy the constraint
    for (int i = 0; i < 24; i++) begin
      rs = 8'($urandom); rt = 8'($urandom); rm = 2'($urandom);
      case (rm)
        AND_UGE: eic = (rs >= rt);
        OR_ULE:  eic = (rs <= rt);
        default: eic = 1'b1;
      endcase
      start_job(0, {24'b0, rs}, {24'b0, rt}, rm);
      wait_done(9);
      check("rnd_ic", cur_ic, eic);
      check("rnd_mode", cur_m, rm);
      if (cur_ic) begin
        op    = rm[0] ? (cur_x[7:0] | rs) : (cur_x[7:0] & rs);
        holds = rm[1] ? (op <= rt) : (op >= rt);
        check("rnd_invariant", holds, 1);
      end else begin
        check("rnd_x_zero", cur_x, 0);
      end
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
